// File: rtl/cal_average_sequencer.sv
// Per-bin averaging sequencer: accumulates 2^L spectra in an external FIFO and
// emits the floor-averaged spectrum on the final pass.
module cal_average_sequencer #(
   parameter int DATA_W = 24,
   parameter int ACC_W  = 28,
   parameter int BINS   = 512,
   parameter int RD_LAT = 2,
   localparam int BIN_W = $clog2(BINS)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              start,
   input  logic [2:0]        cfg_log2_avg,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ACC_W-1:0]  fifo_q,
   input  logic              fifo_empty,
   input  logic              fifo_full,
   output logic              fifo_we,
   output logic              fifo_re,
   output logic [ACC_W-1:0]  fifo_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [BIN_W-1:0]  out_bin,
   output logic              out_last,
   output logic              busy,
   output logic              error
);

   localparam int FL_W = $clog2(RD_LAT + 1);
   localparam int F    = RD_LAT - 1;

   typedef enum logic [2:0] {IDLE, FIRST, ACCUM, LAST, FLUSH} state_t;

   state_t            state_reg, state_next;
   logic [2:0]        l_reg;
   logic [BIN_W-1:0]  bin_reg;
   logic [3:0]        pass_reg;
   logic [FL_W-1:0]   flush_reg;

   logic [2:0]        cfg_l;
   logic [4:0]        n_avg;
   logic              start_ok;
   logic              accept;
   logic              end_of_pass;
   logic              wr_tag;
   logic              out_tag;

   logic              pipe_valid_reg [RD_LAT];
   logic              pipe_add_reg   [RD_LAT];
   logic              pipe_wr_reg    [RD_LAT];
   logic              pipe_out_reg   [RD_LAT];
   logic [ACC_W-1:0]  pipe_data_reg  [RD_LAT];
   logic [BIN_W-1:0]  pipe_bin_reg   [RD_LAT];

   logic signed [ACC_W-1:0] sum;

   logic              fifo_we_reg;
   logic [ACC_W-1:0]  fifo_data_reg;
   logic              out_valid_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic [BIN_W-1:0]  out_bin_reg;
   logic              out_last_reg;
   logic              busy_reg;
   logic              error_reg;

   assign cfg_l       = (cfg_log2_avg > 3'd4) ? 3'd4 : cfg_log2_avg;
   assign n_avg       = 5'd1 << l_reg;
   assign start_ok    = start && (state_reg == IDLE);
   assign accept      = in_valid && ((state_reg == FIRST) || (state_reg == ACCUM) || (state_reg == LAST));
   assign end_of_pass = accept && (bin_reg == BIN_W'(BINS - 1));
   assign wr_tag      = (state_reg == FIRST) || (state_reg == ACCUM);
   assign out_tag     = (state_reg == LAST);

   always_ff @(posedge CLK) begin
      if (RESET) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      fifo_re    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = (cfg_l == 3'd0) ? LAST : FIRST;
         end
         FIRST: begin
            if (end_of_pass) state_next = (l_reg == 3'd1) ? LAST : ACCUM;
         end
         ACCUM: begin
            fifo_re = in_valid;
            if (end_of_pass && ({1'b0, pass_reg} == n_avg - 5'd2)) state_next = LAST;
         end
         LAST: begin
            // L=0 is a pure pass-through; the FIFO holds nothing to read.
            fifo_re = in_valid && (l_reg != 3'd0);
            if (end_of_pass) state_next = FLUSH;
         end
         FLUSH: begin
            if (flush_reg == FL_W'(RD_LAT)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         l_reg     <= 3'd0;
         bin_reg   <= '0;
         pass_reg  <= 4'd0;
         flush_reg <= '0;
      end else if (start_ok) begin
         l_reg     <= cfg_l;
         bin_reg   <= '0;
         pass_reg  <= 4'd0;
         flush_reg <= '0;
      end else begin
         if (accept) begin
            bin_reg  <= end_of_pass ? '0 : bin_reg + 1'b1;
            pass_reg <= end_of_pass ? pass_reg + 4'd1 : pass_reg;
         end
         flush_reg <= (state_reg == FLUSH) ? flush_reg + 1'b1 : '0;
      end
   end

   // The tag pipeline is as deep as the FIFO read latency, so its last stage
   // lines up with fifo_q for the read issued alongside the sample.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pipe_valid_reg[0] <= 1'b0;
         pipe_add_reg[0]   <= 1'b0;
         pipe_wr_reg[0]    <= 1'b0;
         pipe_out_reg[0]   <= 1'b0;
         pipe_data_reg[0]  <= '0;
         pipe_bin_reg[0]   <= '0;
      end else begin
         pipe_valid_reg[0] <= accept;
         pipe_add_reg[0]   <= fifo_re;
         pipe_wr_reg[0]    <= wr_tag;
         pipe_out_reg[0]   <= out_tag;
         pipe_data_reg[0]  <= {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};
         pipe_bin_reg[0]   <= bin_reg;
      end
   end

   generate
      for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
         always_ff @(posedge CLK) begin
            if (RESET) begin
               pipe_valid_reg[gi] <= 1'b0;
               pipe_add_reg[gi]   <= 1'b0;
               pipe_wr_reg[gi]    <= 1'b0;
               pipe_out_reg[gi]   <= 1'b0;
               pipe_data_reg[gi]  <= '0;
               pipe_bin_reg[gi]   <= '0;
            end else begin
               pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
               pipe_add_reg[gi]   <= pipe_add_reg[gi-1];
               pipe_wr_reg[gi]    <= pipe_wr_reg[gi-1];
               pipe_out_reg[gi]   <= pipe_out_reg[gi-1];
               pipe_data_reg[gi]  <= pipe_data_reg[gi-1];
               pipe_bin_reg[gi]   <= pipe_bin_reg[gi-1];
            end
         end
      end
   endgenerate

   assign sum = pipe_data_reg[F] + (pipe_add_reg[F] ? fifo_q : '0);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fifo_we_reg   <= 1'b0;
         fifo_data_reg <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_bin_reg   <= '0;
         out_last_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         fifo_we_reg   <= pipe_valid_reg[F] && pipe_wr_reg[F];
         out_valid_reg <= pipe_valid_reg[F] && pipe_out_reg[F];
         out_last_reg  <= pipe_valid_reg[F] && pipe_out_reg[F] && (pipe_bin_reg[F] == BIN_W'(BINS - 1));
         if (pipe_valid_reg[F] && pipe_wr_reg[F]) fifo_data_reg <= sum;
         if (pipe_valid_reg[F] && pipe_out_reg[F]) begin
            out_data_reg <= DATA_W'(sum >>> l_reg);
            out_bin_reg  <= pipe_bin_reg[F];
         end
         if (start_ok)
            busy_reg <= 1'b1;
         else if (pipe_valid_reg[F] && pipe_out_reg[F] && (pipe_bin_reg[F] == BIN_W'(BINS - 1)))
            busy_reg <= 1'b0;
         if (start_ok)
            error_reg <= 1'b0;
         else if ((in_valid && (state_reg == IDLE)) || (fifo_re && fifo_empty) || (fifo_we_reg && fifo_full))
            error_reg <= 1'b1;
      end
   end

   assign fifo_we   = fifo_we_reg;
   assign fifo_data = fifo_data_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_bin   = out_bin_reg;
   assign out_last  = out_last_reg;
   assign busy      = busy_reg;
   assign error     = error_reg;

endmodule

// File: tb/tb_cal_average_sequencer.sv
// Directed bench for cal_average_sequencer with a behavioural 512 x 28 FIFO
// (two-cycle Q latency) and an expected-output queue checked on every out_valid.
module tb_cal_average_sequencer;
   localparam int DATA_W = 24;
   localparam int ACC_W  = 28;
   localparam int BINS   = 512;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              RESET = 1'b1;
   logic              start = 1'b0;
   logic [2:0]        cfg_log2_avg = 3'd0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic [ACC_W-1:0]  fifo_q;
   logic              fifo_empty, fifo_full;
   logic              fifo_we, fifo_re;
   logic [ACC_W-1:0]  fifo_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [8:0]        out_bin;
   logic              out_last, busy, error;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int we_cnt = 0;
   int re_cnt = 0;
   bit force_empty = 1'b0;

   logic [ACC_W-1:0] mem [BINS];
   logic [8:0]       wp, rp;
   int               cnt;
   logic [ACC_W-1:0] s1, s2;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [8:0]        bin;
      logic              last;
      int                at;
   } exp_t;
   exp_t expq[$];

   cal_average_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .BINS(BINS), .RD_LAT(RD_LAT)) dut (
      .CLK(clk), .RESET(RESET), .start(start), .cfg_log2_avg(cfg_log2_avg),
      .in_valid(in_valid), .in_data(in_data), .fifo_q(fifo_q),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .fifo_we(fifo_we), .fifo_re(fifo_re), .fifo_data(fifo_data),
      .out_valid(out_valid), .out_data(out_data), .out_bin(out_bin),
      .out_last(out_last), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: pop at the RE edge, Q presented two cycles after RE.
   always @(posedge clk) begin
      if (RESET) begin
         wp <= '0; rp <= '0; cnt <= 0; s1 <= '0; s2 <= '0;
      end else begin
         if (fifo_re && cnt > 0) begin
            s1 <= mem[rp];
            rp <= rp + 9'd1;
         end
         s2 <= s1;
         if (fifo_we && cnt < BINS) begin
            mem[wp] <= fifo_data;
            wp <= wp + 9'd1;
         end
         cnt <= cnt + ((fifo_we && cnt < BINS) ? 1 : 0) - ((fifo_re && cnt > 0) ? 1 : 0);
      end
   end

   assign fifo_q     = s2;
   assign fifo_empty = (cnt == 0) || force_empty;
   assign fifo_full  = (cnt == BINS);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   exp_t e;
   always @(negedge clk) begin
      if (fifo_we) we_cnt++;
      if (fifo_re) re_cnt++;
      if (out_valid) begin
         if (expq.size() == 0) begin
            check("unexpected_out_valid", {23'd0, out_bin}, 32'hFFFF_FFFF);
         end else begin
            e = expq.pop_front();
            check("out_data", {8'd0, out_data}, {8'd0, e.data});
            check("out_bin", {23'd0, out_bin}, {23'd0, e.bin});
            check("out_last", {31'd0, out_last}, {31'd0, e.last});
            check("out_latency", cyc, e.at);
            check("busy_vs_last", {31'd0, busy}, {31'd0, ~e.last});
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input bit outp, input logic [DATA_W-1:0] expv, input int bin);
      logic [8:0] b;
      b = bin[8:0];
      in_valid = 1'b1;
      in_data  = d;
      if (outp) expq.push_back('{expv, b, (bin == BINS - 1), cyc + RD_LAT + 1});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic do_start(input logic [2:0] l);
      start = 1'b1;
      cfg_log2_avg = l;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_rise", {31'd0, busy}, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && expq.size() != 0; i++) begin @(posedge clk); #1; end
      check("drain_outputs", expq.size(), 0);
      idle(6);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_fifo_we"}, {31'd0, fifo_we}, 0);
      check({tag, "_fifo_re"}, {31'd0, fifo_re}, 0);
      check({tag, "_fifo_data"}, {4'd0, fifo_data}, 0);
      check({tag, "_out_valid"}, {31'd0, out_valid}, 0);
      check({tag, "_out_data"}, {8'd0, out_data}, 0);
      check({tag, "_out_bin"}, {23'd0, out_bin}, 0);
      check({tag, "_out_last"}, {31'd0, out_last}, 0);
      check({tag, "_busy"}, {31'd0, busy}, 0);
      check({tag, "_error"}, {31'd0, error}, 0);
   endtask

   int v2 [4] = '{100, 200, -50, 2};

   initial begin
      // Reset state
      idle(3);
      RESET = 1'b0;
      idle(1);
      check_all_zero("reset");

      // L=0 pass-through
      we_cnt = 0; re_cnt = 0;
      do_start(3'd0);
      for (int k = 0; k < BINS; k++) send(24'(k), 1'b1, 24'(k), k);
      drain();
      check("l0_we_count", we_cnt, 0);
      check("l0_re_count", re_cnt, 0);
      check("l0_error", {31'd0, error}, 0);
      check("l0_idle_busy", {31'd0, busy}, 0);

      // L=2, 100+200-50+2 = 252 -> 63
      we_cnt = 0; re_cnt = 0;
      do_start(3'd2);
      for (int p = 0; p < 4; p++)
         for (int k = 0; k < BINS; k++) send(24'(v2[p]), p == 3, 24'd63, k);
      drain();
      check("l2_fifo_empty", {31'd0, fifo_empty}, 1);
      check("l2_we_count", we_cnt, 3 * BINS);
      check("l2_re_count", re_cnt, 3 * BINS);
      check("l2_error", {31'd0, error}, 0);

      // L=4 at both rails; cfg 7 clamps to 4
      do_start(3'd7);
      for (int p = 0; p < 16; p++)
         for (int k = 0; k < BINS; k++) send(24'h7FFFFF, p == 15, 24'h7FFFFF, k);
      drain();
      check("l4_pos_error", {31'd0, error}, 0);
      do_start(3'd4);
      for (int p = 0; p < 16; p++)
         for (int k = 0; k < BINS; k++) send(24'h800000, p == 15, 24'h800000, k);
      drain();
      check("l4_neg_error", {31'd0, error}, 0);
      check("l4_fifo_empty", {31'd0, fifo_empty}, 1);

      // L=1 with random gaps: (3k-1701 + -k) >>> 1 = k-851
      do_start(3'd1);
      for (int k = 0; k < BINS; k++) begin
         idle($urandom_range(0, 2));
         send(24'(3 * k - 1701), 1'b0, 24'd0, k);
      end
      idle(10);
      for (int k = 0; k < BINS; k++) begin
         idle($urandom_range(0, 2));
         send(24'(-k), 1'b1, 24'(k - 851), k);
      end
      drain();
      check("l1_error", {31'd0, error}, 0);
      check("l1_fifo_empty", {31'd0, fifo_empty}, 1);

      // Fault: sample while idle
      we_cnt = 0; re_cnt = 0;
      send(24'd5, 1'b0, 24'd0, 0);
      idle(2);
      check("idle_sample_error", {31'd0, error}, 1);
      check("idle_sample_we", we_cnt, 0);
      check("idle_sample_re", re_cnt, 0);
      do_start(3'd1);
      check("start_clears_error", {31'd0, error}, 0);

      // Fault: fifo_empty forced during the read pass; (10+20)/2 = 15
      for (int k = 0; k < BINS; k++) send(24'd10, 1'b0, 24'd0, k);
      for (int k = 0; k < BINS; k++) begin
         force_empty = (k < 5);
         send(24'd20, 1'b1, 24'd15, k);
      end
      force_empty = 1'b0;
      drain();
      check("forced_empty_error", {31'd0, error}, 1);

      // Reset in the middle of an accumulate pass
      do_start(3'd2);
      for (int k = 0; k < BINS; k++) send(24'd7, 1'b0, 24'd0, k);
      for (int k = 0; k < 300; k++) send(24'd7, 1'b0, 24'd0, k);
      RESET = 1'b1;
      @(posedge clk); #1;
      check_all_zero("mid_reset");
      RESET = 1'b0;
      idle(2);

      // Fresh L=1 after reset: (k+5) >>> 1
      we_cnt = 0; re_cnt = 0;
      do_start(3'd1);
      for (int k = 0; k < BINS; k++) send(24'(k), 1'b0, 24'd0, k);
      for (int k = 0; k < BINS; k++) send(24'd5, 1'b1, 24'((k + 5) / 2), k);
      drain();
      check("post_reset_error", {31'd0, error}, 0);
      check("post_reset_fifo_empty", {31'd0, fifo_empty}, 1);
      check("post_reset_we_count", we_cnt, BINS);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
